mvm_job_sched: RTL and testbench

- Job scheduler in front of the MVM control FSM. Accepts job descriptors from the host over a valid/ready interface and buffers them in a small command FIFO.
- Issues each job to the control FSM as a one-cycle start pulse with its addresses and sizes.
- Declares a job complete only after the last output row has drained through the datapath, then reports a tagged completion pulse.
- Rejects degenerate (zero-sized) jobs without touching the datapath.

---
 rtl/mvm_job_sched.sv | 187 ++++++++++++++++++
 tb/tb_mvm_job_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_job_sched.sv
// Job scheduler in front of the MVM control FSM: command FIFO, start issue, drain-aware completion.
// Optional MVM_SCHED_PERF_EN adds a done_cycles output (ISSUE-to-DONE span, saturating).
module mvm_job_sched #(
  parameter int unsigned VEC_ADDRW = 8,
  parameter int unsigned MAT_ADDRW = 9,
  parameter int unsigned VEC_SIZEW = VEC_ADDRW + 1,
  parameter int unsigned MAT_SIZEW = MAT_ADDRW + 1,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [TAG_W-1:0]     cmd_tag,
  input  logic [VEC_ADDRW-1:0] cmd_vec_start_addr,
  input  logic [VEC_SIZEW-1:0] cmd_vec_num_words,
  input  logic [MAT_ADDRW-1:0] cmd_mat_start_addr,
  input  logic [MAT_SIZEW-1:0] cmd_mat_num_rows,
  output logic                 start,
  output logic [VEC_ADDRW-1:0] vec_start_addr,
  output logic [VEC_SIZEW-1:0] vec_num_words,
  output logic [MAT_ADDRW-1:0] mat_start_addr,
  output logic [MAT_SIZEW-1:0] mat_num_rows_per_olane,
  input  logic                 busy,
  input  logic                 accum_last,
  output logic                 done_valid,
  output logic [TAG_W-1:0]     done_tag,
  output logic                 done_err,
  output logic                 sched_busy
`ifdef MVM_SCHED_PERF_EN
  ,
  output logic [15:0]          done_cycles
`endif
);

  localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [VEC_ADDRW-1:0] vec_addr;
    logic [VEC_SIZEW-1:0] vec_words;
    logic [MAT_ADDRW-1:0] mat_addr;
    logic [MAT_SIZEW-1:0] mat_rows;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  cmd_t               mem [CMD_DEPTH];
  cmd_t               head;
  cmd_t               wr_data;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_n;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               reject;
  state_t             state;
  state_t             state_n;
  logic [MAT_SIZEW-1:0] row_cnt;

  assign full      = (count == CNT_W'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr];
  assign wr_data   = '{tag:       cmd_tag,
                       vec_addr:  cmd_vec_start_addr,
                       vec_words: cmd_vec_num_words,
                       mat_addr:  cmd_mat_start_addr,
                       mat_rows:  cmd_mat_num_rows};

  // Descriptor storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Next-state, pop decision and next occupancy.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    reject  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          reject  = (head.vec_words == '0) || (head.mat_rows == '0);
          state_n = reject ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_RUN;
      // Completion needs every last-row pulse and a quiet control FSM.
      S_RUN: begin
        if ((row_cnt == mat_num_rows_per_olane) && !busy) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= S_IDLE;
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      count                  <= '0;
      row_cnt                <= '0;
      start                  <= 1'b0;
      vec_start_addr         <= '0;
      vec_num_words          <= '0;
      mat_start_addr         <= '0;
      mat_num_rows_per_olane <= '0;
      done_valid             <= 1'b0;
      done_tag               <= '0;
      done_err               <= 1'b0;
      sched_busy             <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr                 <= rd_ptr + PTR_W'(1);
        vec_start_addr         <= head.vec_addr;
        vec_num_words          <= head.vec_words;
        mat_start_addr         <= head.mat_addr;
        mat_num_rows_per_olane <= head.mat_rows;
        done_tag               <= head.tag;
      end
      // Counter saturates at its target, so it cannot wrap.
      if (state == S_ISSUE) begin
        row_cnt <= '0;
      end else if ((state == S_RUN) && accum_last && (row_cnt != mat_num_rows_per_olane)) begin
        row_cnt <= row_cnt + MAT_SIZEW'(1);
      end
      start      <= (state_n == S_ISSUE);
      done_valid <= (state_n == S_DONE);
      done_err   <= (state_n == S_DONE) && (state == S_IDLE);
      sched_busy <= (state_n != S_IDLE) || (count_n != '0);
    end
  end

`ifdef MVM_SCHED_PERF_EN
  localparam int unsigned PERF_W   = 16;
  localparam int unsigned PERF_S_W = PERF_W + 1;

  logic [PERF_W-1:0]   perf_cnt;
  logic [PERF_S_W-1:0] perf_sum;

  // perf_cnt covers ISSUE plus elapsed RUN cycles; +2 adds the final RUN and DONE cycles.
  assign perf_sum = {1'b0, perf_cnt} + PERF_S_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt    <= '0;
      done_cycles <= '0;
    end else begin
      if (state == S_ISSUE) begin
        perf_cnt <= PERF_W'(1);
      end else if ((state == S_RUN) && (perf_cnt != '1)) begin
        perf_cnt <= perf_cnt + PERF_W'(1);
      end
      if (state_n == S_DONE) begin
        if (state == S_IDLE)          done_cycles <= '0;
        else if (perf_sum[PERF_W])    done_cycles <= '1;
        else                          done_cycles <= perf_sum[PERF_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mvm_job_sched.sv
// Self-checking bench for mvm_job_sched: directed scenarios plus randomized jobs against a queue-based model.
module tb_mvm_job_sched;

  localparam int unsigned VEC_ADDRW = 8;
  localparam int unsigned MAT_ADDRW = 9;
  localparam int unsigned VEC_SIZEW = VEC_ADDRW + 1;
  localparam int unsigned MAT_SIZEW = MAT_ADDRW + 1;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned CMD_DEPTH = 4;

  logic                 clk;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [TAG_W-1:0]     cmd_tag;
  logic [VEC_ADDRW-1:0] cmd_vec_start_addr;
  logic [VEC_SIZEW-1:0] cmd_vec_num_words;
  logic [MAT_ADDRW-1:0] cmd_mat_start_addr;
  logic [MAT_SIZEW-1:0] cmd_mat_num_rows;
  logic                 start;
  logic [VEC_ADDRW-1:0] vec_start_addr;
  logic [VEC_SIZEW-1:0] vec_num_words;
  logic [MAT_ADDRW-1:0] mat_start_addr;
  logic [MAT_SIZEW-1:0] mat_num_rows_per_olane;
  logic                 busy;
  logic                 accum_last;
  logic                 done_valid;
  logic [TAG_W-1:0]     done_tag;
  logic                 done_err;
  logic                 sched_busy;
`ifdef MVM_SCHED_PERF_EN
  logic [15:0]          done_cycles;
`endif

  mvm_job_sched #(
    .VEC_ADDRW(VEC_ADDRW), .MAT_ADDRW(MAT_ADDRW), .VEC_SIZEW(VEC_SIZEW),
    .MAT_SIZEW(MAT_SIZEW), .TAG_W(TAG_W), .CMD_DEPTH(CMD_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
    .cmd_vec_start_addr(cmd_vec_start_addr), .cmd_vec_num_words(cmd_vec_num_words),
    .cmd_mat_start_addr(cmd_mat_start_addr), .cmd_mat_num_rows(cmd_mat_num_rows),
    .start(start), .vec_start_addr(vec_start_addr), .vec_num_words(vec_num_words),
    .mat_start_addr(mat_start_addr), .mat_num_rows_per_olane(mat_num_rows_per_olane),
    .busy(busy), .accum_last(accum_last),
    .done_valid(done_valid), .done_tag(done_tag), .done_err(done_err),
    .sched_busy(sched_busy)
`ifdef MVM_SCHED_PERF_EN
    , .done_cycles(done_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [TAG_W-1:0]     tag;
    logic [VEC_ADDRW-1:0] va;
    logic [VEC_SIZEW-1:0] vw;
    logic [MAT_ADDRW-1:0] ma;
    logic [MAT_SIZEW-1:0] mr;
  } desc_t;

  desc_t pend[$];   // descriptors waiting to be offered to the DUT
  desc_t exp_q[$];  // accepted descriptors, in the order they must complete
  int errors = 0;
  int checks = 0;
  int last_done = -100;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic desc_t mk(input int tag, input int va, input int vw, input int ma, input int mr);
    desc_t d;
    d.tag = TAG_W'(tag);
    d.va  = VEC_ADDRW'(va);
    d.vw  = VEC_SIZEW'(vw);
    d.ma  = MAT_ADDRW'(ma);
    d.mr  = MAT_SIZEW'(mr);
    return d;
  endfunction

  // Advance one cycle, offering the next pending descriptor to the host port.
  task automatic step();
    bit acc;
    if (pend.size() > 0) begin
      cmd_valid          = 1'b1;
      cmd_tag            = pend[0].tag;
      cmd_vec_start_addr = pend[0].va;
      cmd_vec_num_words  = pend[0].vw;
      cmd_mat_start_addr = pend[0].ma;
      cmd_mat_num_rows   = pend[0].mr;
      acc = (cmd_ready === 1'b1);
    end else begin
      cmd_valid = 1'b0;
      acc = 1'b0;
    end
    @(negedge clk);
    if (acc) exp_q.push_back(pend.pop_front());
  endtask

  // Play the control FSM for the next job: busy for cycles 1..b after ISSUE,
  // accum_last at the given offsets. Done is due at max(last accum, b) + 2.
  task automatic run_job(input int b_in, input int offs_in[$], input bit rnd, input bit noise,
                         output bit rdy_done);
    desc_t d;
    int offs[$];
    int b, a_last, exp_off, cur;
    bit found, err, acc;
    rdy_done = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 80 && !found; w++) begin
      if (start === 1'b1 || done_valid === 1'b1) found = 1'b1;
      else step();
    end
    chk("job_seen", 32'(found), 32'(1));
    chk("model_queue", 32'(exp_q.size() != 0), 32'(1));
    if (!found || exp_q.size() == 0) return;
    d = exp_q.pop_front();
    err = (d.vw == '0) || (d.mr == '0);
    if (err) begin
      chk("rej_done", 32'(done_valid), 32'(1));
      chk("rej_nostart", 32'(start), 32'(0));
      chk("rej_tag", 32'(done_tag), 32'(d.tag));
      chk("rej_err", 32'(done_err), 32'(1));
`ifdef MVM_SCHED_PERF_EN
      chk("rej_cycles", 32'(done_cycles), 32'(0));
`endif
      last_done = cyc;
      step();
      chk("rej_pulse_len", 32'(done_valid), 32'(0));
      chk("rej_nostart_after", 32'(start), 32'(0));
      return;
    end
    if (rnd) begin
      cur = 1;
      for (int k = 0; k < int'(d.mr); k++) begin
        cur += int'($urandom_range(1, 4));
        offs.push_back(cur);
      end
      b = int'($urandom_range(1, cur + 3));
    end else begin
      offs = offs_in;
      b = b_in;
    end
    a_last = 0;
    foreach (offs[k]) if (offs[k] > a_last) a_last = offs[k];
    exp_off = ((a_last > b) ? a_last : b) + 2;
    chk("start", 32'(start), 32'(1));
    chk("start_gap", 32'((cyc - last_done) >= 2), 32'(1));
    chk("cfg_vec_addr", 32'(vec_start_addr), 32'(d.va));
    chk("cfg_vec_words", 32'(vec_num_words), 32'(d.vw));
    chk("cfg_mat_addr", 32'(mat_start_addr), 32'(d.ma));
    chk("cfg_mat_rows", 32'(mat_num_rows_per_olane), 32'(d.mr));
    for (int off = 0; off <= exp_off + 1; off++) begin
      if (off > 0) chk("start_once", 32'(start), 32'(0));
      chk("done_timing", 32'(done_valid), 32'(off == exp_off));
      if (off == 1) chk("sched_busy_run", 32'(sched_busy), 32'(1));
      if (off == exp_off) begin
        chk("done_tag", 32'(done_tag), 32'(d.tag));
        chk("done_err", 32'(done_err), 32'(0));
        chk("cfg_hold", 32'(mat_start_addr), 32'(d.ma));
`ifdef MVM_SCHED_PERF_EN
        chk("done_cycles", 32'(done_cycles), 32'(exp_off + 1));
`endif
        rdy_done = (cmd_ready === 1'b1);
        last_done = cyc;
      end
      busy = (off >= 1 && off <= b);
      acc = noise && (off == 0);
      foreach (offs[k]) if (offs[k] == off) acc = 1'b1;
      accum_last = acc;
      step();
    end
    busy = 1'b0;
    accum_last = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int none[$];
    bit rdy;
    bit found;
    rst = 1'b1; cmd_valid = 1'b0; busy = 1'b0; accum_last = 1'b0;
    cmd_tag = '0; cmd_vec_start_addr = '0; cmd_vec_num_words = '0;
    cmd_mat_start_addr = '0; cmd_mat_num_rows = '0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_done_valid", 32'(done_valid), 32'(0));
    chk("rst_done_tag", 32'(done_tag), 32'(0));
    chk("rst_done_err", 32'(done_err), 32'(0));
    chk("rst_sched_busy", 32'(sched_busy), 32'(0));
    chk("rst_vec_addr", 32'(vec_start_addr), 32'(0));
    chk("rst_mat_rows", 32'(mat_num_rows_per_olane), 32'(0));
    rst = 1'b0;

    // Single job: done only after the 2nd accum_last with busy low
    pend.push_back(mk(3, 'h10, 4, 'h020, 2));
    q = {3, 5};
    run_job(6, q, 1'b0, 1'b0, rdy);

    // Busy falls before the 2nd accum_last
    pend.push_back(mk(5, 'h33, 7, 'h101, 2));
    q = {3, 9};
    run_job(4, q, 1'b0, 1'b0, rdy);

    // Zero-size rejections followed by a good job
    pend.push_back(mk(7, 'h01, 0, 'h002, 3));
    pend.push_back(mk(9, 'h05, 5, 'h006, 0));
    pend.push_back(mk(8, 'h44, 2, 'h0AB, 1));
    run_job(0, none, 1'b0, 1'b0, rdy);
    run_job(0, none, 1'b0, 1'b0, rdy);
    q = {4};
    run_job(2, q, 1'b0, 1'b0, rdy);

    // Back-to-back: job 10 runs while tags 0..3 fill the FIFO
    pend.push_back(mk(10, 'hA0, 3, 'h1A0, 1));
    for (int i = 0; i < 4; i++) pend.push_back(mk(i, 'h20 + i, 1 + i, 'h40 + i, 1 + (i % 3)));
    q = {6};
    run_job(12, q, 1'b0, 1'b0, rdy);
    chk("full_ready", 32'(rdy), 32'(0));
    chk("ready_after_pop", 32'(cmd_ready), 32'(1));
    for (int i = 0; i < 4; i++) run_job(0, none, 1'b1, 1'b0, rdy);

    // accum_last in IDLE and ISSUE must be ignored
    accum_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_accum_done", 32'(done_valid), 32'(0));
      chk("idle_sched_busy", 32'(sched_busy), 32'(0));
    end
    accum_last = 1'b0;
    pend.push_back(mk(11, 'h12, 9, 'h0F0, 2));
    q = {3, 4};
    run_job(2, q, 1'b0, 1'b1, rdy);

    // One word, one row, accum_last 12 cycles after start
    pend.push_back(mk(1, 'h00, 1, 'h000, 1));
    q = {12};
    run_job(10, q, 1'b0, 1'b0, rdy);

    // Randomized jobs, including occasional zero sizes, through a full FIFO
    for (int i = 0; i < 10; i++) begin
      pend.push_back(mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                        ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 511)),
                        int'($urandom_range(0, 511)),
                        ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 3))));
    end
    for (int i = 0; i < 10; i++) run_job(0, none, 1'b1, 1'(i % 2), rdy);

    // Reset in RUN with two jobs queued
    pend.push_back(mk(12, 'h01, 2, 'h003, 2));
    pend.push_back(mk(13, 'h02, 2, 'h004, 1));
    pend.push_back(mk(14, 'h03, 2, 'h005, 1));
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      if (start === 1'b1) found = 1'b1;
      else step();
    end
    chk("rst_job_started", 32'(found), 32'(1));
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accum_last = (i == 1);
      step();
    end
    accum_last = 1'b0;
    chk("pre_rst_sched_busy", 32'(sched_busy), 32'(1));
    pend.delete();
    rst = 1'b1;
    step();
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("mid_rst_start", 32'(start), 32'(0));
    chk("mid_rst_done_valid", 32'(done_valid), 32'(0));
    chk("mid_rst_sched_busy", 32'(sched_busy), 32'(0));
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      busy = 1'($urandom_range(0, 1));
      accum_last = 1'($urandom_range(0, 1));
      step();
      chk("post_rst_no_done", 32'(done_valid), 32'(0));
      chk("post_rst_no_start", 32'(start), 32'(0));
    end
    busy = 1'b0;
    accum_last = 1'b0;
    step();
    pend.push_back(mk(6, 'h77, 3, 'h155, 2));
    q = {2, 5};
    run_job(3, q, 1'b0, 1'b0, rdy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
